// File: rtl/timer_seq_pkg.sv
// Shared definitions for the interval-timer sequencer: timer register map,
// control-register bit positions and the sequencer state encoding.
// Optional feature macro: TIMER_SEQ_ABORT_EN (adds the WR_STOP state).
package timer_seq_pkg;

  // Interval-timer register addresses
  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_CONTROL = 3'd1;
  localparam logic [2:0] REG_PERIODL = 3'd2;
  localparam logic [2:0] REG_PERIODH = 3'd3;

  // Control-register bit positions
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  typedef enum logic [2:0] {
    IDLE,
    WR_PL,
    WR_PH,
    WR_CTRL,
    WAIT_IRQ,
    CLR_STAT,
    DONE
`ifdef TIMER_SEQ_ABORT_EN
    ,
    WR_STOP
`endif
  } state_e;

  // Builds a control-register write value from individual bit requests.
  function automatic logic [15:0] ctrl_word(input logic ito, input logic cont,
                                            input logic start, input logic stop);
    logic [15:0] w;
    w             = '0;
    w[CTRL_ITO]   = ito;
    w[CTRL_CONT]  = cont;
    w[CTRL_START] = start;
    w[CTRL_STOP]  = stop;
    return w;
  endfunction

endpackage

// File: rtl/timer_seq_rr_arbiter.sv
// Round-robin requester selection. The search starts at the index after the
// last accepted grant; the pointer only moves when the grant is taken
// (advance high while valid).
module timer_seq_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               valid
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  // Scan requesters starting at the pointer; compute the pointer update.
  always_comb begin
    int cand;
    cand      = 0;
    grant_idx = '0;
    valid     = 1'b0;
    ptr_d     = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr_q) + k) % NUM_REQ;
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
    if (advance && valid) begin
      if (grant_idx == IDX_W'(NUM_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + 1'b1;
      end
    end
  end

  // Pointer register; returns to requester 0 on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/timer_seq_scheduler.sv
// Timer sequencer: grants one requester at a time, programs the interval
// timer with (delay-1), starts it one-shot with interrupt enabled, waits for
// the interrupt, clears the status register and pulses done for the granted
// requester. A delay of 0 completes immediately without touching the timer.
// Optional feature macro: TIMER_SEQ_ABORT_EN (abort input, done_aborted
// output and a STOP write when the granted requester aborts while waiting).
module timer_seq_scheduler
  import timer_seq_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [32*NUM_REQ-1:0] req_delay,
`ifdef TIMER_SEQ_ABORT_EN
  input  logic [NUM_REQ-1:0]   abort,
  output logic                 done_aborted,
`endif
  output logic [NUM_REQ-1:0]   done,
  output logic                 busy,
  output logic [2:0]           av_address,
  output logic                 av_chipselect,
  output logic                 av_write_n,
  output logic [15:0]          av_writedata,
  input  logic                 timer_irq
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      period_q, period_d;
`ifdef TIMER_SEQ_ABORT_EN
  logic             aborted_q, aborted_d;
`endif

  logic [IDX_W-1:0] arb_idx;
  logic             arb_valid;
  logic             arb_advance;
  logic [31:0]      sel_delay;

  // Grants are only taken in IDLE, so the pointer moves once per grant.
  assign arb_advance = (state_q == IDLE);

  timer_seq_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .advance   (arb_advance),
    .grant_idx (arb_idx),
    .valid     (arb_valid)
  );

  // Delay of the requester that would be granted this cycle.
  always_comb begin
    sel_delay = req_delay[32*arb_idx +: 32];
  end

  // Next-state logic and the timer bus / done outputs decoded from state.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    period_d      = period_q;
`ifdef TIMER_SEQ_ABORT_EN
    aborted_d     = aborted_q;
    done_aborted  = 1'b0;
`endif
    done          = '0;
    av_chipselect = 1'b0;
    av_write_n    = 1'b1;
    av_address    = '0;
    av_writedata  = '0;

    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          idx_d    = arb_idx;
          period_d = sel_delay - 32'd1;
`ifdef TIMER_SEQ_ABORT_EN
          aborted_d = 1'b0;
`endif
          state_d  = (sel_delay == 32'd0) ? DONE : WR_PL;
        end
      end
      WR_PL: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = REG_PERIODL;
        av_writedata  = period_q[15:0];
        state_d       = WR_PH;
      end
      WR_PH: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = REG_PERIODH;
        av_writedata  = period_q[31:16];
        state_d       = WR_CTRL;
      end
      WR_CTRL: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = REG_CONTROL;
        av_writedata  = ctrl_word(1'b1, 1'b0, 1'b1, 1'b0);
        state_d       = WAIT_IRQ;
      end
      WAIT_IRQ: begin
        // The interrupt wins over a same-cycle abort.
        if (timer_irq) begin
          state_d = CLR_STAT;
        end
`ifdef TIMER_SEQ_ABORT_EN
        else if (abort[idx_q]) begin
          state_d = WR_STOP;
        end
`endif
      end
`ifdef TIMER_SEQ_ABORT_EN
      WR_STOP: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = REG_CONTROL;
        av_writedata  = ctrl_word(1'b0, 1'b0, 1'b0, 1'b1);
        aborted_d     = 1'b1;
        state_d       = CLR_STAT;
      end
`endif
      CLR_STAT: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = REG_STATUS;
        av_writedata  = 16'h0000;
        state_d       = DONE;
      end
      DONE: begin
        done[idx_q] = 1'b1;
`ifdef TIMER_SEQ_ABORT_EN
        done_aborted = aborted_q;
`endif
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);

  // Sequencer state and the grant context latched at grant time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      period_q  <= '0;
`ifdef TIMER_SEQ_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      period_q  <= period_d;
`ifdef TIMER_SEQ_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

endmodule

// File: tb/tb_timer_seq_scheduler.sv
// Bench for timer_seq_scheduler: table of single grants, hand-written
// multi-cycle sequences and randomized rounds against a requester/timer model.
module tb_timer_seq_scheduler;
  import timer_seq_pkg::*;

  localparam int NUM_REQ = 4;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic [NUM_REQ-1:0]     req = '0;
  logic [32*NUM_REQ-1:0]  req_delay = '0;
  logic                   timer_irq = 1'b0;
  logic [NUM_REQ-1:0]     done;
  logic                   busy;
  logic [2:0]             av_address;
  logic                   av_chipselect;
  logic                   av_write_n;
  logic [15:0]            av_writedata;
`ifdef TIMER_SEQ_ABORT_EN
  logic [NUM_REQ-1:0]     abort = '0;
  logic                   done_aborted;
`endif

  timer_seq_scheduler #(.NUM_REQ(NUM_REQ)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req           (req),
    .req_delay     (req_delay),
`ifdef TIMER_SEQ_ABORT_EN
    .abort         (abort),
    .done_aborted  (done_aborted),
`endif
    .done          (done),
    .busy          (busy),
    .av_address    (av_address),
    .av_chipselect (av_chipselect),
    .av_write_n    (av_write_n),
    .av_writedata  (av_writedata),
    .timer_irq     (timer_irq)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] addr; logic [15:0] data; int cyc; } wr_t;
  typedef struct { int idx; logic ab; int cyc; } dn_t;
  typedef struct {
    logic [3:0] mask; logic [31:0] delay; int exp_idx;
    int exp_nwr; logic [15:0] exp_pl; logic [15:0] exp_ph;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int irq_lat = 0;
  int irq_cd = 0;
  bit armed = 0;
  bit auto_drop = 1;
  wr_t wq[$];
  dn_t dq[$];
  logic [18:0] ewq[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: sample outputs on the falling edge, emulate timer and requesters.
  task automatic tick();
    logic ab;
    @(negedge clk);
    cyc++;
    if (reset_n) begin
      if (av_chipselect && !av_write_n) begin
        wq.push_back('{av_address, av_writedata, cyc});
        if (av_address == REG_CONTROL && av_writedata[CTRL_START]) begin
          armed = 1; irq_cd = irq_lat;
        end
        if (av_address == REG_CONTROL && av_writedata[CTRL_STOP]) armed = 0;
        if (av_address == REG_STATUS) timer_irq = 1'b0;
      end
      if (armed) begin
        if (irq_cd == 0) begin timer_irq = 1'b1; armed = 0; end
        else irq_cd--;
      end
      if (done != '0) begin
        chk("done_onehot", longint'($onehot(done)), 1);
`ifdef TIMER_SEQ_ABORT_EN
        ab = done_aborted;
`else
        ab = 1'b0;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
          if (done[i]) begin
            dq.push_back('{i, ab, cyc});
            if (auto_drop) req[i] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic wait_done(input int n, input int budget);
    int c;
    c = 0;
    while (dq.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk("done_within_budget", longint'(dq.size() >= n), 1);
  endtask

  // Expected timer traffic for one grant with delay d.
  function automatic void model_writes(input logic [31:0] d);
    logic [31:0] p;
    if (d != 32'd0) begin
      p = d - 32'd1;
      ewq.push_back({REG_PERIODL, p[15:0]});
      ewq.push_back({REG_PERIODH, p[31:16]});
      ewq.push_back({REG_CONTROL, 16'h0005});
      ewq.push_back({REG_STATUS, 16'h0000});
    end
  endfunction

  task automatic cmp_writes(input string tag);
    chk({tag, "_nwr"}, wq.size(), ewq.size());
    for (int i = 0; i < wq.size() && i < ewq.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), {wq[i].addr, wq[i].data}, ewq[i]);
    wq.delete();
    ewq.delete();
  endtask

  task automatic set_all_delay(input logic [31:0] d);
    for (int i = 0; i < NUM_REQ; i++) req_delay[32*i +: 32] = d;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cs"}, av_chipselect, 0);
    chk({tag, "_wn"}, av_write_n, 1);
    chk({tag, "_addr"}, av_address, 0);
    chk({tag, "_data"}, av_writedata, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req = '0; timer_irq = 1'b0; armed = 0;
`ifdef TIMER_SEQ_ABORT_EN
    abort = '0;
`endif
    tick();
    chk_reset_outputs("rst");
    tick();
    reset_n = 1'b1;
    tick();
    wq.delete(); dq.delete(); ewq.delete();
  endtask

  vec_t tbl[8];

  initial begin
    int start;
    int mptr;
    int n;
    logic [3:0] pend;
    logic [31:0] dly[NUM_REQ];
    int exp_order[$];

    tbl[0] = '{4'b0001, 32'd100,        0, 4, 16'h0063, 16'h0000};
    tbl[1] = '{4'b0001, 32'h0001_2345,  0, 4, 16'h2344, 16'h0001};
    tbl[2] = '{4'b0100, 32'd0,          2, 0, 16'h0000, 16'h0000};
    tbl[3] = '{4'b0110, 32'd1,          1, 4, 16'h0000, 16'h0000};
    tbl[4] = '{4'b1010, 32'h8000_0000,  3, 4, 16'hFFFF, 16'h7FFF};
    tbl[5] = '{4'b1111, 32'hFFFF_FFFF,  0, 4, 16'hFFFE, 16'hFFFF};
    tbl[6] = '{4'b1000, 32'd2,          3, 4, 16'h0001, 16'h0000};
    tbl[7] = '{4'b0011, 32'h0001_0000,  0, 4, 16'hFFFF, 16'h0000};

    do_reset();

    // Table: one grant per entry; round-robin pointer carries over.
    for (int v = 0; v < 8; v++) begin
      irq_lat = v % 3;
      set_all_delay(tbl[v].delay);
      req = tbl[v].mask;
      start = cyc;
      wait_done(1, 100);
      req = '0;
      tick();
      chk($sformatf("t%0d_ndone", v), dq.size(), 1);
      if (dq.size() > 0) chk($sformatf("t%0d_idx", v), dq[0].idx, tbl[v].exp_idx);
`ifdef TIMER_SEQ_ABORT_EN
      if (dq.size() > 0) chk($sformatf("t%0d_aborted", v), dq[0].ab, 0);
`endif
      if (wq.size() > 0) chk($sformatf("t%0d_first_wr_cyc", v), wq[0].cyc, start + 1);
      if (tbl[v].exp_nwr != 0) begin
        ewq.push_back({REG_PERIODL, tbl[v].exp_pl});
        ewq.push_back({REG_PERIODH, tbl[v].exp_ph});
        ewq.push_back({REG_CONTROL, 16'h0005});
        ewq.push_back({REG_STATUS, 16'h0000});
      end
      cmp_writes($sformatf("t%0d", v));
      dq.delete();
    end

    // All requesters held: fair rotation and one IDLE cycle between grants.
    do_reset();
    auto_drop = 0;
    irq_lat = 0;
    set_all_delay(32'd5);
    req = 4'hF;
    wait_done(5, 200);
    req = '0;
    auto_drop = 1;
    tick();
    chk("rr_ndone", dq.size(), 5);
    for (int k = 0; k < 5 && k < dq.size(); k++)
      chk($sformatf("rr_idx%0d", k), dq[k].idx, k % 4);
    chk("rr_nwr", wq.size(), 20);
    for (int k = 1; k < 5 && k < dq.size() && 4 * k < wq.size(); k++)
      chk($sformatf("rr_gap%0d", k), wq[4*k].cyc - dq[k-1].cyc, 2);
    wq.delete(); dq.delete();

    // Req and delay changes after grant are ignored.
    irq_lat = 2;
    set_all_delay(32'h0000_0100);
    req = 4'b0010;
    tick();
    chk("hold_busy", busy, 1);
    req_delay[32 +: 32] = 32'd5;
    req = '0;
    wait_done(1, 100);
    tick();
    chk("hold_busy_after", busy, 0);
    chk("hold_ndone", dq.size(), 1);
    if (dq.size() > 0) chk("hold_idx", dq[0].idx, 1);
    model_writes(32'h0000_0100);
    cmp_writes("hold");
    dq.delete();

    // Reset while waiting for the interrupt.
    do_reset();
    irq_lat = 10000;
    set_all_delay(32'd50);
    req = 4'b0100;
    for (int k = 0; k < 6; k++) tick();
    chk("mid_nwr", wq.size(), 3);
    chk("mid_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    timer_irq = 1'b0; armed = 0; req = '0;
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick(); tick();
    chk("mid_no_done", dq.size(), 0);
    wq.delete(); dq.delete();
    irq_lat = 1;
    set_all_delay(32'd7);
    req = 4'b1001;
    wait_done(1, 100);
    req = '0;
    tick();
    if (dq.size() > 0) chk("mid_next_idx", dq[0].idx, 0);
    model_writes(32'd7);
    cmp_writes("mid_next");
    dq.delete();

`ifdef TIMER_SEQ_ABORT_EN
    // Abort while waiting: STOP write, status clear, aborted completion.
    irq_lat = 10000;
    set_all_delay(32'd10);
    req = 4'b0010;
    for (int k = 0; k < 6; k++) tick();
    abort = 4'b0010;
    wait_done(1, 50);
    abort = '0; req = '0;
    tick();
    if (dq.size() > 0) chk("ab_idx", dq[0].idx, 1);
    if (dq.size() > 0) chk("ab_flag", dq[0].ab, 1);
    ewq.push_back({REG_PERIODL, 16'h0009});
    ewq.push_back({REG_PERIODH, 16'h0000});
    ewq.push_back({REG_CONTROL, 16'h0005});
    ewq.push_back({REG_CONTROL, 16'h0008});
    ewq.push_back({REG_STATUS, 16'h0000});
    cmp_writes("ab");
    dq.delete();

    // Abort and interrupt together: interrupt wins.
    req = 4'b0010;
    for (int k = 0; k < 6; k++) tick();
    armed = 0;
    timer_irq = 1'b1;
    abort = 4'b0010;
    wait_done(1, 50);
    abort = '0; req = '0;
    tick();
    if (dq.size() > 0) chk("abirq_flag", dq[0].ab, 0);
    model_writes(32'd10);
    cmp_writes("abirq");
    dq.delete();
`endif

    // Randomized rounds against the requester/arbitration model.
    do_reset();
    mptr = 0;
    for (int r = 0; r < 12; r++) begin
      pend = 4'($urandom_range(1, 15));
      for (int i = 0; i < NUM_REQ; i++) begin
        if ($urandom_range(0, 3) == 0) dly[i] = 32'd0;
        else if ($urandom_range(0, 1) == 1) dly[i] = $urandom;
        else dly[i] = 32'($urandom_range(1, 300));
        req_delay[32*i +: 32] = dly[i];
      end
      irq_lat = $urandom_range(0, 4);
      req = pend;
      exp_order.delete();
      while (pend != 4'b0000) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (pend[(mptr + k) % NUM_REQ]) begin
            n = (mptr + k) % NUM_REQ;
            break;
          end
        end
        exp_order.push_back(n);
        model_writes(dly[n]);
        pend[n] = 1'b0;
        mptr = (n + 1) % NUM_REQ;
      end
      wait_done(exp_order.size(), 60 * exp_order.size());
      req = '0;
      tick();
      chk($sformatf("r%0d_ndone", r), dq.size(), exp_order.size());
      for (int k = 0; k < exp_order.size() && k < dq.size(); k++)
        chk($sformatf("r%0d_idx%0d", r, k), dq[k].idx, exp_order[k]);
      cmp_writes($sformatf("r%0d", r));
      dq.delete();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/timer_seq_scheduler.md
TIMER_SEQ_SCHEDULER -- requirements
Module: timer_seq_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, giving the number of requesters (2..8).
REQ-002 SHALL have clk, input, 1, system clock.
REQ-003 SHALL have reset_n, input, 1, reset (asynchronous, active-low).
REQ-004 SHALL have req, input, NUM_REQ, level request; held until the matching done pulse.
REQ-005 SHALL have req_delay, input, 32*NUM_REQ, per-requester delay in clk cycles; slice i is bits [32i+31:32i].
REQ-006 SHALL have done, output, NUM_REQ, one-cycle completion pulse for the granted requester.
REQ-007 SHALL have busy, output, 1, high in every state except IDLE.
REQ-008 SHALL have av_address, output, 3, interval-timer register address.
REQ-009 SHALL have av_chipselect, output, 1, timer select.
REQ-010 SHALL have av_write_n, output, 1, active-low write.
REQ-011 SHALL have av_writedata, output, 16, timer write data.
REQ-012 SHALL have timer_irq, input, 1, timer interrupt (level).

Function
REQ-013 SHALL implement states IDLE, WR_PL, WR_PH, WR_CTRL, WAIT_IRQ, CLR_STAT and DONE.
REQ-014 SHALL, in IDLE with any req bit set, grant round-robin starting from the index after the last grant (index 0 after reset).
REQ-015 SHALL latch the granted index and P = delay-1 at grant, then go to WR_PL.
REQ-016 SHALL, for a granted delay of 0, go directly to DONE with no timer access.
REQ-017 SHALL issue exactly one single-cycle write per write state: WR_PL addr 2, data P[15:0]; WR_PH addr 3, data P[31:16]; WR_CTRL addr 1, data 0x0005 (START | ITO, CONT=0).
REQ-018 SHALL hold av_chipselect=0 and av_write_n=1 in all other states and cycles.
REQ-019 SHALL remain in WAIT_IRQ until timer_irq is sampled high.
REQ-020 SHALL, in CLR_STAT, write addr 0, data 0x0000, then move to DONE.
REQ-021 SHALL, in DONE, pulse done[granted] for one cycle and return to IDLE.
REQ-022 SHALL hold a requester's done to exactly one pulse per grant.
REQ-023 SHALL ignore req changes and req_delay changes between grant and DONE.
REQ-024 SHALL re-arbitrate no earlier than the cycle after DONE, so back-to-back grants are separated by one IDLE cycle.

Reset
REQ-025 SHALL, on reset_n low, force IDLE, done=0, busy=0, av_chipselect=0, av_write_n=1, av_address=0, av_writedata=0 and RR pointer=0.
REQ-026 SHALL, when reset is asserted mid-sequence, drop the grant without a done pulse; the timer shares reset.

Configuration
REQ-027 SHALL, with TIMER_SEQ_ABORT_EN defined, add input abort (NUM_REQ bits) and output done_aborted (1 bit, valid with done).
REQ-028 SHALL, with TIMER_SEQ_ABORT_EN defined and abort[granted] high in WAIT_IRQ, write addr 1, data 0x0008 (STOP) in state WR_STOP, then go to CLR_STAT and DONE with done_aborted=1.
REQ-029 SHALL, when abort and timer_irq are high in the same cycle, give irq priority (done_aborted=0).
REQ-030 SHALL, with TIMER_SEQ_ABORT_EN undefined, omit abort, done_aborted and WR_STOP.

Structure
REQ-031 SHALL place in package timer_seq_pkg: the register addresses (STATUS=0, CONTROL=1, PERIODL=2, PERIODH=3), the control bit positions (ITO=0, CONT=1, START=2, STOP=3) and the state enum.
REQ-032 SHALL implement round-robin selection in sub-module timer_seq_rr_arbiter (req, advance, grant index, valid).

Verification
REQ-033 Single requester: req[0]=1, delay=100 -> writes (2,0x0063), (3,0x0000), (1,0x0005); after irq, write (0,0x0000); done[0] pulses once.
REQ-034 Delay 0x0001_2345 -> period writes 0x2344 then 0x0001.
REQ-035 All four requesters held high -> grants in order 0,1,2,3,0; no requester is starved.
REQ-036 Delay 0 on req[2] -> done[2] pulses with no av_chipselect activity.
REQ-037 With TIMER_SEQ_ABORT_EN: abort in WAIT_IRQ -> write (1,0x0008), then (0,0x0000); done with done_aborted=1. Abort and irq in the same cycle -> done_aborted=0.
REQ-038 Reset during WAIT_IRQ -> all outputs at reset values, no done pulse, next grant starts at index 0.
